pipeline_ctl: RTL
=================

Name: pipeline_ctl

Overview:
- Central stall/flush sequencer for the five-stage pipelined LEGv8 core.
- Drives the PC enable, plus per-register enable and flush (bubble) controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves four conditions: load-use hazards, taken branches resolved in MEM, multi-cycle data-memory waits, and HLT retirement.
- Sits beside the datapath; the pipeline registers consume its outputs as clock-enable and bubble-select.

Parameters:
REGADDRSIZE, 5, register address width
XZR, 31, zero-register index; never creates a hazard
MEM_TIMEOUT, 255, maximum MEMWAIT cycles before FAULT; must be ≥1

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
idex_memread  in  1  instruction in ID/EX is a load
idex_rd  in  REGADDRSIZE  destination register of ID/EX instruction
ifid_rn  in  REGADDRSIZE  first source register of IF/ID instruction
ifid_rm  in  REGADDRSIZE  second source register of IF/ID instruction
ifid_usesrn  in  1  ifid_rn is actually read
ifid_usesrm  in  1  ifid_rm is actually read
exmem_branchtaken  in  1  branch in EX/MEM resolved taken
dmem_req  in  1  EX/MEM instruction accesses data memory
dmem_ready  in  1  data memory completes access this cycle
halt_in  in  1  HLT instruction is in WB
pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load a bubble (control fields zeroed)
halted  out  1  core halted
fault  out  1  memory timeout occurred

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- States: RUN, MEMWAIT, HALT, FAULT. A registered wait counter has width clog2(MEM_TIMEOUT+1).
- Outputs are combinational from state and inputs. Default: all enables 1, all flushes 0.
- While rst=1: all enables 1, all flushes 1, halted=0, fault=0. Next state is RUN, counter 0. This lets the reset-less pipeline registers fill with bubbles. Reset overrides every state, including mid-MEMWAIT.
- hazard = idex_memread & (idex_rd≠XZR) & ((ifid_usesrn & ifid_rn==idex_rd) | (ifid_usesrm & ifid_rm==idex_rd)).
- freeze = pc/ifid/idex/exmem_en=0, memwb_en=1, memwb_flush=1 (WB receives a bubble, so no double write).
- RUN, evaluated in this priority order:
  1. halt_in: all enables 0 → HALT.
  2. dmem_req & !dmem_ready: freeze, counter←1 → MEMWAIT.
  3. exmem_branchtaken: all enables 1, ifid/idex/exmem_flush=1 (PC loads the target).
  4. hazard: pc_en=0, ifid_en=0, idex_flush=1, other enables 1; one-cycle stall. The hazard re-evaluates next cycle and is then false because the load has moved on.
  5. Otherwise: defaults.
- MEMWAIT:
  - dmem_ready=1: outputs as the RUN rules 3–5 evaluated this cycle → RUN. The counter is ignored; ready on the timeout cycle wins.
  - Otherwise, if counter==MEM_TIMEOUT: all enables 0 → FAULT.
  - Otherwise: freeze, counter+1.
  - halt_in is ignored in MEMWAIT, since WB holds a bubble.
- HALT: all enables 0, halted=1; sticky until rst.
- FAULT: all enables 0, fault=1; sticky until rst.
- A branch or hazard coinciding with an unready memory access: the memory stall takes precedence and the branch/hazard is applied on the release cycle.
- A flush of a register whose enable is 0 has no effect; the implementation never generates that combination except in freeze.

Optional Feature:
PIPECTL_PERF_EN:
- Defined: adds outputs stall_cycles[31:0] and flush_events[31:0], registered, cleared by rst, saturating at 0xFFFFFFFF.
  - stall_cycles increments each cycle pc_en=0 in RUN or MEMWAIT.
  - flush_events increments once per branch flush.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Load-use: idex_memread=1, idex_rd=3, ifid_rn=3, usesrn=1 → one cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle (idex_memread=0) all enables 1.
- XZR/no-use: idex_rd=31 matching ifid_rn, or ifid_usesrn=0 with matching rn → no stall.
- Memory wait: dmem_req=1, dmem_ready=0 for 4 cycles then 1 → freeze for 4 cycles with memwb_flush=1; release cycle all enables 1; state RUN.
- Timeout: MEM_TIMEOUT=3, dmem_ready held 0 → fault=1 after cycle 4, all enables 0; persists until rst, after which fault=0 and RUN.
- Branch vs hazard: exmem_branchtaken=1 with hazard=1 → ifid/idex/exmem_flush=1, pc_en=1, no stall; with PIPECTL_PERF_EN, flush_events 0→1.
- Halt: halt_in=1 → next cycle halted=1, all enables 0; rst=1 → all enables 1 and all flushes 1 that cycle, halted=0 after.

Source files
------------

// File: rtl/pipeline_ctl.sv
// Stall/flush sequencer for the five-stage LEGv8 pipeline: PC and pipeline-register enables/bubbles.
// Optional performance counters are enabled by defining PIPECTL_PERF_EN.
module pipeline_ctl #(
  parameter int unsigned REGADDRSIZE = 5,
  parameter int unsigned XZR         = 31,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   idex_memread,
  input  logic [REGADDRSIZE-1:0] idex_rd,
  input  logic [REGADDRSIZE-1:0] ifid_rn,
  input  logic [REGADDRSIZE-1:0] ifid_rm,
  input  logic                   ifid_usesrn,
  input  logic                   ifid_usesrm,
  input  logic                   exmem_branchtaken,
  input  logic                   dmem_req,
  input  logic                   dmem_ready,
  input  logic                   halt_in,
  output logic                   pc_en,
  output logic                   ifid_en,
  output logic                   idex_en,
  output logic                   exmem_en,
  output logic                   memwb_en,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   exmem_flush,
  output logic                   memwb_flush,
  output logic                   halted,
  output logic                   fault
`ifdef PIPECTL_PERF_EN
  ,
  output logic [31:0]            stall_cycles,
  output logic [31:0]            flush_events
`endif
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StMemwait = 2'd1;
  localparam logic [1:0] StHalt    = 2'd2;
  localparam logic [1:0] StFault   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            hazard;
  logic            release_run;
  logic            branch_flush;

  assign hazard = idex_memread && (idex_rd != REGADDRSIZE'(XZR)) &&
                  ((ifid_usesrn && (ifid_rn == idex_rd)) ||
                   (ifid_usesrm && (ifid_rm == idex_rd)));

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    memwb_flush  = 1'b0;
    halted       = 1'b0;
    fault        = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    release_run  = 1'b0;
    branch_flush = 1'b0;

    if (rst) begin
      // Bubbles flow into the reset-less pipeline registers while reset is held.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
      state_d     = StRun;
      cnt_d       = '0;
    end else begin
      case (state_q)
        StRun: begin
          if (halt_in) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
            state_d = StHalt;
          end else if (dmem_req && !dmem_ready) begin
            {pc_en, ifid_en, idex_en, exmem_en} = 4'b0;
            memwb_flush = 1'b1;
            cnt_d       = CntW'(1);
            state_d     = StMemwait;
          end else begin
            release_run = 1'b1;
          end
        end
        StMemwait: begin
          if (dmem_ready) begin
            release_run = 1'b1;
            state_d     = StRun;
          end else if (cnt_q == CntW'(MEM_TIMEOUT)) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
            state_d = StFault;
          end else begin
            {pc_en, ifid_en, idex_en, exmem_en} = 4'b0;
            memwb_flush = 1'b1;
            cnt_d       = cnt_q + CntW'(1);
          end
        end
        StHalt: begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
          halted = 1'b1;
        end
        default: begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
          fault = 1'b1;
        end
      endcase

      // Branch beats load-use: the stalled consumer is squashed anyway.
      if (release_run) begin
        if (exmem_branchtaken) begin
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
          exmem_flush  = 1'b1;
          branch_flush = 1'b1;
        end else if (hazard) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PIPECTL_PERF_EN
  logic stall_inc;
  assign stall_inc = !pc_en && ((state_q == StRun) || (state_q == StMemwait));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_inc && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
      if (branch_flush && (flush_events != 32'hFFFF_FFFF)) flush_events <= flush_events + 32'd1;
    end
  end
`else
  logic unused_branch_flush;
  assign unused_branch_flush = branch_flush;
`endif

endmodule
